mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory access controller. Sits directly downstream of the EX/MEM pipeline register
//  and consumes its memory-control, address (ALU result) and store-data fields. Issues req/ack
//  transactions to data memory, builds byte enables, forms aligned/extended load data and stalls
//  the pipeline while an access is in flight.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max WAIT cycles without dmem_ack_in before bus error; legal range 1..255
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   reset, asynchronous, active-low (asserted at 0)
//  mem_read_in      in   4   [3]=load enable, [2:0]=funct3 (000 LB,001 LH,010 LW,100 LBU,101 LHU)
//  mem_write_in     in   3   [2]=store enable, [1:0]=size (00 SB,01 SH,10 SW)
//  addr_in          in   32  byte address (EX/MEM ALU result)
//  store_data_in    in   32  rs2 value (EX/MEM read_data2)
//  load_data_out    out  32  formatted load result, registered, valid in DONE and held until next load
//  mem_stall_out    out  1   freeze PC/IF/ID/EX/MEM registers this cycle
//  misaligned_out   out  1   combinational: enabled access with illegal alignment
//  bus_error_out    out  1   registered 1-cycle pulse in DONE when access timed out
//  dmem_req_out     out  1   request, registered
//  dmem_we_out      out  1   1=write, 0=read; valid with req
//  dmem_addr_out    out  32  word address {addr_in[31:2],2'b00}; valid with req
//  dmem_wdata_out   out  32  replicated store data: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d
//  dmem_be_out      out  4   byte enables: SB 0001<<a[1:0], SH 0011<<a[1:0], SW 1111, loads 1111
//  dmem_rdata_in    in   32  read word, valid when dmem_ack_in=1
//  dmem_ack_in      in   1   completes request; sampled only in WAIT
// BEHAVIOUR
//  - States: IDLE, WAIT, DONE. access = mem_read_in[3] | mem_write_in[2]; both set -> treat as load.
//  - misaligned = access & ((LH/LHU/SH & a[0]) | (LW/SW & a[1:0]!=0)); LB/LBU/SB never misaligned.
//  - IDLE: access & !misaligned -> register req=1, we, addr, wdata, be; ->WAIT; stall=1 this cycle.
//    access & misaligned -> no request, no stall, stay IDLE; trap handling is downstream.
//    no access -> stall=0.
//  - WAIT: req held with all dmem_* outputs stable; stall=1; timeout counter increments.
//    ack=1 -> req=0 next edge, capture formatted rdata (loads only), ->DONE.
//    counter reaches TIMEOUT_CYCLES without ack -> req=0, load_data_out=0, bus_error_out=1, ->DONE.
//  - DONE: stall=0 (pipeline advances at this edge); unconditional ->IDLE; never re-issues.
//  - Minimum access = 3 cycles (IDLE, WAIT with ack, DONE). Stores update load_data_out: no.
//  - Load format: w = rdata >> (8*a[1:0]); LB sext w[7:0], LBU zext w[7:0], LH sext w[15:0],
//    LHU zext w[15:0], LW w. Shift uses addr registered at request time, not live addr_in.
//  - ack outside WAIT ignored. Ack on the same edge the counter expires: ack wins, no bus error.
//  - Reset (any state, incl. mid-WAIT): state=IDLE, counter=0, dmem_req_out=0, dmem_we_out=0,
//    dmem_addr_out=0, dmem_wdata_out=0, dmem_be_out=0, load_data_out=0, bus_error_out=0.
//    mem_stall_out=0 and misaligned_out follow inputs combinationally. Late ack after reset ignored.
// STRUCTURE
//  - Shared header mem_defs.vh: funct3 load/store codes, state encodings, enable bit positions;
//    used also by the decoder and EX/MEM register so encodings live in one place.
//  - One sub-module: load_formatter (combinational: rdata, byte offset, funct3 -> 32-bit result).
//  - Store byte-enable/replication logic and FSM stay inline.
// TESTING
//  1 Reset mid-WAIT: rst=0 while req=1 -> req=0, load_data_out=0, stall=0 same cycle; late ack ignored.
//  2 LW a=0x100, ack 2 cycles after req, rdata=0xDEADBEEF -> stall 3 cycles, load_data_out=0xDEADBEEF.
//  3 LB a=0x103 rdata=0x80AABBCC -> 0xFFFFFF80; LBU same -> 0x00000080; LHU a=0x102 -> 0x000080AA.
//  4 SB a=0x101 data=0x12345678 -> be=0010, wdata=0x78787878, addr=0x100, we=1; load_data_out held.
//  5 LW a=0x102 -> misaligned_out=1, req never asserted, stall=0; SH a=0x103 -> same.
//  6 LW with no ack for 16 WAIT cycles -> bus_error_out pulse 1 cycle, load_data_out=0, back to IDLE.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access unit: funct3/size codes, enable bit
// positions, FSM states and the alignment rule used by decoder and EX/MEM stages.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int LOAD_EN_BIT  = 3;
  localparam int STORE_EN_BIT = 2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Load funct3[1:0] and store size share one encoding, so a single rule covers both.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] byteOff);
    case (size)
      SZ_H:    return byteOff[0];
      SZ_W:    return byteOff != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus between the MEM-stage access unit (master) and data memory (slave).
interface mem_access_unit_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack
  );

endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Combinational load alignment: shifts the read word down to the requested byte
// lane and sign/zero extends according to the load funct3.
module mem_access_unit_load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = rdata_i >> {byte_off_i, 3'b000};
    result_o = shifted;
    case (funct3_i)
      F3_LB:   result_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  result_o = {24'd0, shifted[7:0]};
      F3_LH:   result_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  result_o = {16'd0, shifted[15:0]};
      F3_LW:   result_o = shifted;
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: issues req/ack bus transactions, builds
// byte enables and store lanes, formats load data and stalls the pipeline meanwhile.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        mem_read_i,
  input  logic [2:0]        mem_write_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       store_data_i,
  output logic [31:0]       load_data_o,
  output logic              mem_stall_o,
  output logic              misaligned_o,
  output logic              bus_error_o,
  mem_access_unit_if.master dmem
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        isLoad, access, startAccess, timeoutHit;
  logic [1:0]  accSize;
  logic [3:0]  storeBe;
  logic [31:0] storeWdata;
  logic [31:0] formatted;

  logic        req_q, we_q, isLoad_q, busErr_q;
  logic [31:0] addr_q, wdata_q, loadData_q;
  logic [3:0]  be_q;
  logic [1:0]  byteOff_q;
  logic [2:0]  funct3_q;
  logic [7:0]  tmoCnt_q;

  // A simultaneous load and store enable is treated as a load.
  assign isLoad       = mem_read_i[LOAD_EN_BIT];
  assign access       = isLoad | mem_write_i[STORE_EN_BIT];
  assign accSize      = isLoad ? mem_read_i[1:0] : mem_write_i[1:0];
  assign misaligned_o = access & isMisaligned(accSize, addr_i[1:0]);
  assign startAccess  = access & ~misaligned_o;
  assign timeoutHit   = (tmoCnt_q == TMO_LAST);

  always_comb begin
    storeBe    = 4'b1111;
    storeWdata = store_data_i;
    if (!isLoad) begin
      case (mem_write_i[1:0])
        SZ_B: begin
          storeBe    = 4'b0001 << addr_i[1:0];
          storeWdata = {4{store_data_i[7:0]}};
        end
        SZ_H: begin
          storeBe    = 4'b0011 << addr_i[1:0];
          storeWdata = {2{store_data_i[15:0]}};
        end
        default: begin
          storeBe    = 4'b1111;
          storeWdata = store_data_i;
        end
      endcase
    end
  end

  mem_access_unit_load_formatter u_load_formatter (
    .rdata_i    (dmem.rdata),
    .byte_off_i (byteOff_q),
    .funct3_i   (funct3_q),
    .result_o   (formatted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (startAccess) state_d = S_WAIT;
      S_WAIT:  if (dmem.ack || timeoutHit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // DONE releases the stall so the pipeline advances on the edge that returns to IDLE.
  always_comb begin
    mem_stall_o = 1'b0;
    case (state_q)
      S_IDLE:  mem_stall_o = startAccess;
      S_WAIT:  mem_stall_o = 1'b1;
      default: mem_stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      byteOff_q  <= 2'd0;
      funct3_q   <= 3'd0;
      isLoad_q   <= 1'b0;
      tmoCnt_q   <= 8'd0;
      loadData_q <= 32'd0;
      busErr_q   <= 1'b0;
    end else begin
      busErr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (startAccess) begin
            req_q     <= 1'b1;
            we_q      <= ~isLoad;
            addr_q    <= {addr_i[31:2], 2'b00};
            wdata_q   <= storeWdata;
            be_q      <= storeBe;
            byteOff_q <= addr_i[1:0];
            funct3_q  <= mem_read_i[2:0];
            isLoad_q  <= isLoad;
            tmoCnt_q  <= 8'd0;
          end
        end
        S_WAIT: begin
          // An ack arriving on the expiry edge still completes normally.
          if (dmem.ack) begin
            req_q <= 1'b0;
            if (isLoad_q) loadData_q <= formatted;
          end else if (timeoutHit) begin
            req_q      <= 1'b0;
            loadData_q <= 32'd0;
            busErr_q   <= 1'b1;
          end else begin
            tmoCnt_q <= tmoCnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.req    = req_q;
  assign dmem.we     = we_q;
  assign dmem.addr   = addr_q;
  assign dmem.wdata  = wdata_q;
  assign dmem.be     = be_q;
  assign load_data_o = loadData_q;
  assign bus_error_o = busErr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected bus requests
// and completions; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  mem_read_i = 4'd0;
  logic [2:0]  mem_write_i = 3'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] store_data_i = 32'd0;
  logic [31:0] load_data_o;
  logic        mem_stall_o, misaligned_o, bus_error_o;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .load_data_o  (load_data_o),
    .mem_stall_o  (mem_stall_o),
    .misaligned_o (misaligned_o),
    .bus_error_o  (bus_error_o),
    .dmem         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          chkW;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          stalls;
  } done_t;

  req_t  reqQ[$];
  done_t doneQ[$];
  int    assertCount = 0;
  int    failCount = 0;
  int    doneSeen = 0;
  int    ackDelay = 1;
  logic [31:0] ackData = 32'd0;
  bit    lateAck = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input string detail);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  task automatic expectReq(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be, input bit chkW);
    req_t r;
    r.we = we; r.addr = a; r.wdata = wd; r.be = be; r.chkW = chkW;
    reqQ.push_back(r);
  endtask

  task automatic expectDone(input logic [31:0] data, input logic err, input int stalls);
    done_t d;
    d.data = data; d.err = err; d.stalls = stalls;
    doneQ.push_back(d);
  endtask

  // Memory model: acks on the ackDelay-th cycle req is seen high (0 = never).
  initial begin
    int cyc = 0;
    bus.ack   = 1'b0;
    bus.rdata = 32'h0BAD_F00D;
    forever begin
      @(posedge clk); #1;
      if (bus.req) cyc++; else cyc = 0;
      if (lateAck || (bus.req && cyc == ackDelay)) begin
        bus.ack   = 1'b1;
        bus.rdata = ackData;
      end else begin
        bus.ack   = 1'b0;
        bus.rdata = 32'h0BAD_F00D;
      end
    end
  end

  initial begin
    bit    prevReq = 1'b0;
    int    stallRun = 0;
    req_t  cur;
    done_t exp;
    cur.we = 1'b0; cur.addr = 32'd0; cur.wdata = 32'd0; cur.be = 4'd0; cur.chkW = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevReq  = 1'b0;
        stallRun = 0;
      end else begin
        if (bus.req && !prevReq) begin
          if (reqQ.size() == 0) reportFail("req_unexpected", "got dmem request, expected none");
          else begin
            cur = reqQ.pop_front();
            checkOutput("req_we", 32'(bus.we), 32'(cur.we));
            checkOutput("req_addr", bus.addr, cur.addr);
            checkOutput("req_be", 32'(bus.be), 32'(cur.be));
            if (cur.chkW) checkOutput("req_wdata", bus.wdata, cur.wdata);
          end
        end else if (bus.req) begin
          checkOutput("wait_addr_stable", bus.addr, cur.addr);
          checkOutput("wait_be_stable", 32'(bus.be), 32'(cur.be));
        end
        if (mem_stall_o) stallRun++;
        else if (stallRun > 0) begin
          if (doneQ.size() == 0) reportFail("done_unexpected", "got completion, expected none");
          else begin
            exp = doneQ.pop_front();
            checkOutput("load_data", load_data_o, exp.data);
            checkOutput("bus_error", 32'(bus_error_o), 32'(exp.err));
            checkOutput("stall_cycles", 32'(stallRun), 32'(exp.stalls));
            checkOutput("req_dropped", 32'(bus.req), 32'd0);
          end
          stallRun = 0;
          doneSeen++;
        end else begin
          checkOutput("bus_error_idle", 32'(bus_error_o), 32'd0);
        end
        prevReq = bus.req;
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                               input logic [31:0] d, input int delay, input logic [31:0] rdata);
    int startDone;
    startDone    = doneSeen;
    ackDelay     = delay;
    ackData      = rdata;
    mem_read_i   = rd;
    mem_write_i  = wr;
    addr_i       = a;
    store_data_i = d;
    #1;
    checkOutput("issue_misaligned", 32'(misaligned_o), 32'd0);
    checkOutput("issue_stall", 32'(mem_stall_o), 32'd1);
    @(posedge clk); #1;
    mem_read_i   = 4'd0;
    mem_write_i  = 3'd0;
    addr_i       = 32'hFFFF_FFFF;
    store_data_i = 32'hA5A5_A5A5;
    for (int i = 0; i < 40 && doneSeen == startDone; i++) begin
      @(posedge clk); #1;
    end
    if (doneSeen == startDone) reportFail("done_timeout", "got no completion, expected one within 40 cycles");
  endtask

  task automatic checkMisaligned(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a);
    mem_read_i  = rd;
    mem_write_i = wr;
    addr_i      = a;
    #1;
    checkOutput("misaligned_flag", 32'(misaligned_o), 32'd1);
    checkOutput("misaligned_stall", 32'(mem_stall_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("misaligned_no_req", 32'(bus.req), 32'd0);
    mem_read_i  = 4'd0;
    mem_write_i = 3'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_req", 32'(bus.req), 32'd0);
    checkOutput("rst_we", 32'(bus.we), 32'd0);
    checkOutput("rst_addr", bus.addr, 32'd0);
    checkOutput("rst_wdata", bus.wdata, 32'd0);
    checkOutput("rst_be", 32'(bus.be), 32'd0);
    checkOutput("rst_load_data", load_data_o, 32'd0);
    checkOutput("rst_bus_error", 32'(bus_error_o), 32'd0);
    checkOutput("rst_stall", 32'(mem_stall_o), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    expectReq(1'b0, 32'h100, 32'd0, 4'hF, 1'b0);
    expectDone(32'hDEADBEEF, 1'b0, 3);
    applyStimulus(4'b1010, 3'b000, 32'h100, 32'd0, 2, 32'hDEADBEEF);

    expectReq(1'b0, 32'h100, 32'd0, 4'hF, 1'b0);
    expectDone(32'hFFFFFF80, 1'b0, 2);
    applyStimulus(4'b1000, 3'b000, 32'h103, 32'd0, 1, 32'h80AABBCC);

    expectReq(1'b0, 32'h100, 32'd0, 4'hF, 1'b0);
    expectDone(32'h00000080, 1'b0, 2);
    applyStimulus(4'b1100, 3'b000, 32'h103, 32'd0, 1, 32'h80AABBCC);

    expectReq(1'b0, 32'h100, 32'd0, 4'hF, 1'b0);
    expectDone(32'h000080AA, 1'b0, 2);
    applyStimulus(4'b1101, 3'b000, 32'h102, 32'd0, 1, 32'h80AABBCC);

    expectReq(1'b1, 32'h100, 32'h78787878, 4'b0010, 1'b1);
    expectDone(32'h000080AA, 1'b0, 2);
    applyStimulus(4'b0000, 3'b100, 32'h101, 32'h12345678, 1, 32'h0);

    expectReq(1'b1, 32'h100, 32'h56785678, 4'b1100, 1'b1);
    expectDone(32'h000080AA, 1'b0, 3);
    applyStimulus(4'b0000, 3'b101, 32'h102, 32'h12345678, 2, 32'h0);

    expectReq(1'b1, 32'h108, 32'hCAFEF00D, 4'b1111, 1'b1);
    expectDone(32'h000080AA, 1'b0, 2);
    applyStimulus(4'b0000, 3'b110, 32'h108, 32'hCAFEF00D, 1, 32'h0);

    checkMisaligned(4'b1010, 3'b000, 32'h102);
    checkMisaligned(4'b0000, 3'b101, 32'h103);
    checkMisaligned(4'b1101, 3'b000, 32'h101);
    checkMisaligned(4'b0000, 3'b110, 32'h10A);

    expectReq(1'b0, 32'h200, 32'd0, 4'hF, 1'b0);
    expectDone(32'd0, 1'b1, 17);
    applyStimulus(4'b1010, 3'b000, 32'h200, 32'd0, 0, 32'h0);

    expectReq(1'b0, 32'h200, 32'd0, 4'hF, 1'b0);
    expectDone(32'hFFFF8001, 1'b0, 17);
    applyStimulus(4'b1001, 3'b000, 32'h202, 32'd0, 16, 32'h80010000);

    expectReq(1'b0, 32'h104, 32'd0, 4'hF, 1'b0);
    expectDone(32'h11223344, 1'b0, 2);
    applyStimulus(4'b1010, 3'b000, 32'h104, 32'd0, 1, 32'h11223344);

    // Reset while the request is outstanding, then a stray ack afterwards.
    expectReq(1'b0, 32'h300, 32'd0, 4'hF, 1'b0);
    ackDelay   = 10;
    ackData    = 32'h55AA55AA;
    mem_read_i = 4'b1010;
    addr_i     = 32'h300;
    @(posedge clk); #1;
    mem_read_i = 4'd0;
    addr_i     = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    checkOutput("req_before_reset", 32'(bus.req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midwait_rst_req", 32'(bus.req), 32'd0);
    checkOutput("midwait_rst_load_data", load_data_o, 32'd0);
    checkOutput("midwait_rst_stall", 32'(mem_stall_o), 32'd0);
    checkOutput("midwait_rst_addr", bus.addr, 32'd0);
    @(negedge clk); #2;
    rst_n   = 1'b1;
    lateAck = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("late_ack_req", 32'(bus.req), 32'd0);
      checkOutput("late_ack_stall", 32'(mem_stall_o), 32'd0);
      checkOutput("late_ack_load_data", load_data_o, 32'd0);
    end
    lateAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    expectReq(1'b0, 32'h104, 32'd0, 4'hF, 1'b0);
    expectDone(32'h11223344, 1'b0, 2);
    applyStimulus(4'b1010, 3'b000, 32'h104, 32'd0, 1, 32'h11223344);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("req_queue_drained", 32'(reqQ.size()), 32'd0);
    checkOutput("done_queue_drained", 32'(doneQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
